// File: rtl/cp0_reg.sv
// CP0 register file and exception commit unit for the single-issue MIPS pipeline.
// Holds BadVAddr/Count/Compare/Status/Cause/EPC and drives flush/redirect.
module cp0_reg #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [40:0] cp0_bus,
    input  logic [31:0] epc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_vaddr_i,
    input  logic [31:0] excepttype_i,
    input  logic [5:0]  ext_int,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_pending,
    output logic        flush,
    output logic [31:0] new_pc
);

    localparam logic [7:0] A_BADV    = 8'h40;
    localparam logic [7:0] A_COUNT   = 8'h48;
    localparam logic [7:0] A_COMPARE = 8'h58;
    localparam logic [7:0] A_STATUS  = 8'h60;
    localparam logic [7:0] A_CAUSE   = 8'h68;
    localparam logic [7:0] A_EPC     = 8'h70;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] r_badv;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_tick;

    logic        w_eret;
    logic        w_exc;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic [4:0]  w_exc_code;
    logic        w_addr_err;
    logic [31:0] w_epc_next;
    logic        w_exl;
    logic        w_timer_hit;

    assign w_eret      = (excepttype_i == 32'hE);
    assign w_exc       = (|excepttype_i) & ~w_eret;
    assign w_we        = cp0_bus[40] & ~w_exc & ~w_eret;
    assign w_addr      = cp0_bus[39:32];
    assign w_wdata     = cp0_bus[31:0];
    assign w_exl       = r_status[1];
    assign w_epc_next  = is_in_delayslot_i ? (epc_i - 32'd4) : epc_i;
    assign w_timer_hit = (r_count == r_compare);
    assign w_addr_err  = (excepttype_i == 32'h4) | (excepttype_i == 32'h5);

    // Unknown nonzero codes commit as reserved instruction.
    always_comb begin
        w_exc_code = 5'd10;
        case (excepttype_i)
            32'h1:   w_exc_code = 5'd0;
            32'h4:   w_exc_code = 5'd4;
            32'h5:   w_exc_code = 5'd5;
            32'h8:   w_exc_code = 5'd8;
            32'h9:   w_exc_code = 5'd9;
            32'hA:   w_exc_code = 5'd10;
            32'hC:   w_exc_code = 5'd12;
            default: w_exc_code = 5'd10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (w_we && w_addr == A_COUNT) begin
                r_count <= w_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_compare <= 32'd0;
        end else if (w_we && w_addr == A_COMPARE) begin
            r_compare <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= STATUS_RST;
        end else if (w_exc) begin
            r_status[1] <= 1'b1;
        end else if (w_eret) begin
            r_status[1] <= 1'b0;
        end else if (w_we && w_addr == A_STATUS) begin
            r_status <= (r_status & ~STATUS_WMASK)
                      | (w_wdata & STATUS_WMASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= 32'd0;
        end else begin
            r_cause[15:10] <= {ext_int[5] | r_cause[30], ext_int[4:0]};
            if (w_we && w_addr == A_COMPARE) begin
                r_cause[30] <= 1'b0;
            end else if (w_timer_hit) begin
                r_cause[30] <= 1'b1;
            end
            if (w_we && w_addr == A_CAUSE) begin
                r_cause[9:8] <= w_wdata[9:8];
            end
            if (w_exc) begin
                r_cause[6:2] <= w_exc_code;
                if (!w_exl) begin
                    r_cause[31] <= is_in_delayslot_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc <= 32'd0;
        end else if (w_exc) begin
            if (!w_exl) begin
                r_epc <= w_epc_next;
            end
        end else if (w_we && w_addr == A_EPC) begin
            r_epc <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badv <= 32'd0;
        end else if (w_exc && w_addr_err) begin
            r_badv <= bad_vaddr_i;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            A_BADV:    rdata = r_badv;
            A_COUNT:   rdata = r_count;
            A_COMPARE: rdata = r_compare;
            A_STATUS:  rdata = r_status;
            A_CAUSE:   rdata = r_cause;
            A_EPC:     rdata = r_epc;
            default:   rdata = 32'd0;
        endcase
    end

    always_comb begin
        flush  = 1'b0;
        new_pc = 32'd0;
        if (!rst) begin
            if (w_eret) begin
                flush  = 1'b1;
                new_pc = r_epc;
            end else if (w_exc) begin
                flush  = 1'b1;
                new_pc = EXC_VECTOR;
            end
        end
    end

    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign int_pending = r_status[0] & ~r_status[1]
                       & (|(r_cause[15:8] & r_status[15:8]));

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios then random traffic
// compared against a field-level reference model.
module tb_cp0_reg;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] cp0_bus;
    logic [31:0] epc_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_vaddr_i;
    logic [31:0] excepttype_i;
    logic [5:0]  ext_int;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_pending;
    logic        flush;
    logic [31:0] new_pc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk               (clk),
        .rst               (rst),
        .cp0_bus           (cp0_bus),
        .epc_i             (epc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .bad_vaddr_i       (bad_vaddr_i),
        .excepttype_i      (excepttype_i),
        .ext_int           (ext_int),
        .raddr             (raddr),
        .rdata             (rdata),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .int_pending       (int_pending),
        .flush             (flush),
        .new_pc            (new_pc)
    );

    // Reference model, one variable per architectural field.
    logic [31:0] m_badv, m_count, m_compare, m_epc;
    logic        m_tick;
    logic [7:0]  m_im;
    logic        m_exl, m_ie;
    logic        m_ti, m_bd;
    logic [5:0]  m_iphw;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0040_0000;
        s[15:8] = m_im;
        s[1] = m_exl;
        s[0] = m_ie;
        return s;
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = 32'd0;
        c[31] = m_bd;
        c[30] = m_ti;
        c[15:10] = m_iphw;
        c[9:8] = m_ipsw;
        c[6:2] = m_code;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'd64:   return m_badv;
            8'd72:   return m_count;
            8'd88:   return m_compare;
            8'd96:   return m_status();
            8'd104:  return m_cause();
            8'd112:  return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] m_excode(input logic [31:0] t);
        case (t)
            32'h1:   return 5'd0;
            32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC: return t[4:0];
            default: return 5'd10;
        endcase
    endfunction

    task automatic model_reset();
        m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0;
        m_tick = 0; m_im = 0; m_exl = 0; m_ie = 0;
        m_ti = 0; m_bd = 0; m_iphw = 0; m_ipsw = 0; m_code = 0;
    endtask

    task automatic model_update();
        logic eret, exc, we, ti_now, tick_now;
        logic [7:0] a;
        logic [31:0] wd, cnt_now, cmp_now;
        if (rst) begin
            model_reset();
            return;
        end
        eret = (excepttype_i == 32'hE);
        exc = (excepttype_i != 0) && !eret;
        we = cp0_bus[40] && !exc && !eret;
        a = cp0_bus[39:32];
        wd = cp0_bus[31:0];
        ti_now = m_ti;
        tick_now = m_tick;
        cnt_now = m_count;
        cmp_now = m_compare;
        m_iphw = {ext_int[5] | ti_now, ext_int[4:0]};
        m_tick = !tick_now;
        if (we && a == 8'd72) m_count = wd;
        else if (tick_now) m_count = cnt_now + 1;
        if (we && a == 8'd88) begin
            m_compare = wd;
            m_ti = 0;
        end else if (cnt_now == cmp_now) m_ti = 1;
        if (we && a == 8'd96) begin
            m_im = wd[15:8];
            m_exl = wd[1];
            m_ie = wd[0];
        end
        if (we && a == 8'd104) m_ipsw = wd[9:8];
        if (we && a == 8'd112) m_epc = wd;
        if (exc) begin
            if (!m_exl) begin
                m_epc = is_in_delayslot_i ? epc_i - 4 : epc_i;
                m_bd = is_in_delayslot_i;
            end
            m_exl = 1;
            m_code = m_excode(excepttype_i);
            if (excepttype_i == 4 || excepttype_i == 5) m_badv = bad_vaddr_i;
        end
        if (eret) m_exl = 0;
    endtask

    task automatic compare_outputs();
        logic fl;
        logic [31:0] np;
        logic ip;
        fl = !rst && (excepttype_i != 0);
        np = !fl ? 32'd0 : (excepttype_i == 32'hE) ? m_epc : VEC;
        ip = m_ie && !m_exl && ((m_cause() & m_status() & 32'h0000_FF00) != 0);
        check("flush", flush, fl);
        check("new_pc", new_pc, np);
        check("int_pending", int_pending, ip);
        check("status", status_o, m_status());
        check("cause", cause_o, m_cause());
        check("epc", epc_o, m_epc);
        check("rdata", rdata, m_read(raddr));
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        cp0_bus = '0;
        excepttype_i = 0;
        is_in_delayslot_i = 0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        cp0_bus = {1'b1, a, d};
        step();
        cp0_bus = '0;
    endtask

    logic [7:0]  addrs [7] = '{8'd64, 8'd72, 8'd88, 8'd96, 8'd104, 8'd112, 8'd8};
    logic [31:0] codes [10] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA,
                                32'hC, 32'hE, 32'h3, 32'h40};

    initial begin
        rst = 1;
        idle();
        epc_i = 0;
        bad_vaddr_i = 0;
        ext_int = 0;
        raddr = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        // Reset values; flush stays low while rst even with an exception.
        excepttype_i = 32'h8;
        for (int i = 0; i < 6; i++) begin
            raddr = addrs[i];
            #1;
            check("rst_read", rdata, (i == 3) ? 32'h0040_0000 : 32'd0);
        end
        check("rst_flush", flush, 1'b0);
        check("rst_newpc", new_pc, 32'd0);
        check("rst_int", int_pending, 1'b0);
        step();
        idle();
        rst = 0;

        // Timer interrupt.
        raddr = 8'd72;
        bus_wr(8'd96, 32'h0000_8001);
        bus_wr(8'd88, 32'd5);
        bus_wr(8'd72, 32'd0);
        repeat (13) step();
        check("ti_set", cause_o[30], 1'b1);
        check("ip15", cause_o[15], 1'b1);
        check("timer_int", int_pending, 1'b1);
        bus_wr(8'd88, 32'd1000);
        check("ti_clr", cause_o[30], 1'b0);
        bus_wr(8'd96, 32'd0);

        // Syscall.
        excepttype_i = 32'h8;
        epc_i = 32'hBFC00100;
        #1;
        check("sys_flush", flush, 1'b1);
        check("sys_newpc", new_pc, VEC);
        step();
        idle();
        check("sys_epc", epc_o, 32'hBFC00100);
        check("sys_code", cause_o[6:2], 5'd8);
        check("sys_exl", status_o[1], 1'b1);
        check("sys_bd", cause_o[31], 1'b0);
        bus_wr(8'd96, 32'd0);

        // AdEL in a delay slot, then ERET.
        excepttype_i = 32'h4;
        is_in_delayslot_i = 1;
        epc_i = 32'h80001004;
        bad_vaddr_i = 32'h80000003;
        raddr = 8'd64;
        step();
        idle();
        check("adel_epc", epc_o, 32'h80001000);
        check("adel_bd", cause_o[31], 1'b1);
        check("adel_badv", rdata, 32'h80000003);
        excepttype_i = 32'hE;
        #1;
        check("eret_newpc", new_pc, 32'h80001000);
        step();
        idle();
        check("eret_exl", status_o[1], 1'b0);

        // Nested exception; coincident bus write to EPC is dropped.
        excepttype_i = 32'h9;
        epc_i = 32'h80002000;
        step();
        excepttype_i = 32'hC;
        epc_i = 32'h80003000;
        cp0_bus = {1'b1, 8'd112, 32'h12345678};
        step();
        idle();
        check("nest_epc", epc_o, 32'h80002000);
        check("nest_code", cause_o[6:2], 5'd12);
        excepttype_i = 32'hE;
        step();
        idle();

        // External interrupt line 2.
        bus_wr(8'd96, 32'h0000_1001);
        ext_int = 6'b000100;
        #1;
        check("ext_int_early", int_pending, 1'b0);
        step();
        check("ext_int", int_pending, 1'b1);

        // Reset during a flush.
        excepttype_i = 32'h8;
        rst = 1;
        #1;
        check("rst_flush2", flush, 1'b0);
        step();
        rst = 0;
        idle();
        ext_int = 0;
        check("rst2_status", status_o, 32'h0040_0000);
        check("rst2_epc", epc_o, 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [7:0] a;
            a = addrs[$urandom_range(0, 6)];
            excepttype_i = ($urandom_range(0, 99) < 80) ? 32'd0
                         : codes[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) == 0) begin
                cp0_bus = {1'b1, a, (a == 8'd72 || a == 8'd88)
                          ? 32'($urandom_range(0, 20)) : 32'($urandom)};
            end else begin
                cp0_bus = '0;
            end
            epc_i = $urandom;
            bad_vaddr_i = $urandom;
            is_in_delayslot_i = 1'($urandom);
            ext_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            raddr = addrs[$urandom_range(0, 6)];
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
